// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_arb_pkg
// Brief    : Shared defaults, width helper and types for the adder arbiter.
// Revision : 1.0
// ============================================================================
package adder_arb_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int W_DEFAULT    = 13;

    // A one-requester build still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [W_DEFAULT:0]               sum_t;
    typedef logic [$clog2(NREQ_DEFAULT)-1:0]  id_t;

endpackage : adder_arb_pkg
`default_nettype wire

// File: rtl/adder_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after rr_ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  rr_ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  index_o,
    output logic            valid_o
);

    int             j;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant_o = '0;
        index_o = '0;
        found   = 1'b0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            idx = IDW'(j);
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                index_o = idx;
            end
        end
        valid_o = found;
        if (enable_i && found) begin
            grant_o[index_o] = 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adder_arbiter
// Brief    : Round-robin time-sharing of one W-bit adder among NREQ requesters
//            with a valid/ready request side and a tagged, backpressured
//            response. Define ADDER_ARB_PIPE_EN for an extra register stage.
// Revision : 1.0
// ============================================================================
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int W    = W_DEFAULT,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            r_enable,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    output logic            resp_valid,
    output logic [IDW-1:0]  resp_id,
    output logic [W-1:0]    resp_data,
    output logic            resp_carry,
    input  logic            resp_ready
);

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            resp_valid_q, resp_valid_d;
    logic [IDW-1:0]  resp_id_q, resp_id_d;
    logic [W:0]      resp_sum_q, resp_sum_d;

    logic            adv;
    logic            can_accept;
    logic            arb_en;
    logic            accept;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  gidx;
    logic            gvalid;
    logic [W-1:0]    a_sel, b_sel;
    logic [W:0]      sum;

    assign adv    = !resp_valid_q || resp_ready;
    // Grants are suppressed during reset so nothing is accepted into a flushing pipe.
    assign arb_en = can_accept && !r_enable;
    assign accept = gvalid && arb_en;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .enable_i (arb_en),
        .grant_o  (grant),
        .index_o  (gidx),
        .valid_o  (gvalid)
    );

    assign req_ready = grant;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gidx) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
            end
        end
        sum = {1'b0, a_sel} + {1'b0, b_sel};
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

`ifdef ADDER_ARB_PIPE_EN
    logic            s1_valid_q, s1_valid_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;
    logic [W:0]      s1_sum_q, s1_sum_d;

    assign can_accept = !s1_valid_q || adv;

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_id_d      = s1_id_q;
        s1_sum_d     = s1_sum_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        if (can_accept) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_id_d  = gidx;
                s1_sum_d = sum;
            end
        end
        if (adv) begin
            resp_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                resp_id_d  = s1_id_q;
                resp_sum_d = s1_sum_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_enable) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_sum_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_sum_q   <= s1_sum_d;
        end
    end
`else
    assign can_accept = adv;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        if (adv) begin
            resp_valid_d = accept;
            if (accept) begin
                resp_id_d  = gidx;
                resp_sum_d = sum;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (r_enable) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_sum_q[W-1:0];
    assign resp_carry = resp_sum_q[W];

endmodule : adder_arbiter
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_arbiter
// Brief    : Directed self-checking bench for adder_arbiter (either build of
//            ADDER_ARB_PIPE_EN), with an in-order response scoreboard.
// Revision : 1.0
// ============================================================================
module tb_adder_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 13;
    localparam int IDW  = 2;
`ifdef ADDER_ARB_PIPE_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 1;
`endif

    logic              clk = 1'b0;
    logic              r_enable;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_data;
    logic              resp_carry;
    logic              resp_ready;

    logic [W-1:0]      op_a [NREQ];
    logic [W-1:0]      op_b [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    adder_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk        (clk),
        .r_enable   (r_enable),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .resp_ready (resp_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard entries are {id, carry, data}; held tracks a stalled response.
    logic [IDW+W:0] sb_q [$];
    logic [IDW+W:0] exp_e;
    logic [IDW+W:0] held;
    logic           held_v = 1'b0;

    always @(negedge clk) begin
        if (r_enable) begin
            sb_q.delete();
            held_v = 1'b0;
        end else begin
            if (resp_valid && resp_ready) begin
                check_eq("sb_nonempty", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    exp_e = sb_q.pop_front();
                    check_eq("sb_resp", 32'({resp_id, resp_carry, resp_data}), 32'(exp_e));
                end
            end
            if (resp_valid && !resp_ready) begin
                if (held_v) begin
                    check_eq("hold_stable", 32'({resp_id, resp_carry, resp_data}), 32'(held));
                end
                held   = {resp_id, resp_carry, resp_data};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back({IDW'(i), {1'b0, op_a[i]} + {1'b0, op_b[i]}});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int lat;
    int nacc;
    int exp_rr [5] = '{1, 2, 4, 8, 1};
    int exp_fs [3] = '{8, 1, 8};

    initial begin
        r_enable   = 1'b1;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 0);
        cyc();
        cyc();
        check_eq("rst_resp_valid", 32'(resp_valid), 0);
        check_eq("rst_resp_id",    32'(resp_id),    0);
        check_eq("rst_resp_data",  32'(resp_data),  0);
        check_eq("rst_resp_carry", 32'(resp_carry), 0);

        // Single request from requester 1: 100 + 23
        r_enable  = 1'b0;
        req_valid = 4'b0010;
        op_a[1]   = 13'd100;
        op_b[1]   = 13'd23;
        #1;
        check_eq("single_grant", 32'(req_ready), 2);
        cyc();
        req_valid = 4'b0000;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            cyc();
            lat++;
        end
        check_eq("single_latency", 32'(lat), LAT);
        check_eq("single_id",    32'(resp_id),    1);
        check_eq("single_data",  32'(resp_data),  123);
        check_eq("single_carry", 32'(resp_carry), 0);
        cyc();

        // Overflow from requester 2 (pointer now at 2): 0x1FFF + 1
        req_valid = 4'b0100;
        op_a[2]   = 13'h1FFF;
        op_b[2]   = 13'h0001;
        #1;
        check_eq("ovf_grant", 32'(req_ready), 4);
        cyc();
        req_valid = 4'b0000;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            cyc();
            lat++;
        end
        check_eq("ovf_latency", 32'(lat), LAT);
        check_eq("ovf_id",    32'(resp_id),    2);
        check_eq("ovf_data",  32'(resp_data),  0);
        check_eq("ovf_carry", 32'(resp_carry), 1);
        cyc();
        cyc();

        // Round robin with all requesters held
        r_enable = 1'b1;
        cyc();
        r_enable = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = 13'(i * 100 + 7);
            op_b[i] = 13'(i + 1);
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("rr_grant", 32'(req_ready), 32'(exp_rr[k]));
            cyc();
        end
        req_valid = 4'h0;
        repeat (3) cyc();

        // Backpressure: consumer stalls for five cycles
        r_enable = 1'b1;
        cyc();
        r_enable   = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        nacc = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (|(req_valid & req_ready)) nacc++;
            cyc();
        end
        #1;
        check_eq("bp_accepts",   32'(nacc), LAT);
        check_eq("bp_req_ready", 32'(req_ready), 0);
        check_eq("bp_valid",     32'(resp_valid), 1);
        check_eq("bp_held_id",   32'(resp_id), 0);
        resp_ready = 1'b1;
        #1;
        check_eq("bp_resume_grant", 32'(req_ready), 32'(1 << LAT));
        repeat (4) cyc();
        req_valid = 4'h0;
        repeat (4) cyc();

        // Fairness skip: pointer at 1 with requesters 0 and 3 active
        r_enable = 1'b1;
        cyc();
        r_enable  = 1'b0;
        req_valid = 4'b0001;
        #1;
        check_eq("fair_first", 32'(req_ready), 1);
        cyc();
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("fair_grant", 32'(req_ready), 32'(exp_fs[k]));
            cyc();
        end
        req_valid = 4'h0;
        repeat (4) cyc();

        // Reset while a response is pending
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        cyc();
        cyc();
        check_eq("mid_pre_valid", 32'(resp_valid), 1);
        r_enable = 1'b1;
        #1;
        check_eq("mid_rst_req_ready", 32'(req_ready), 0);
        cyc();
        check_eq("mid_post_valid", 32'(resp_valid), 0);
        r_enable = 1'b0;
        #1;
        check_eq("mid_post_grant", 32'(req_ready), 1);
        cyc();
        req_valid  = 4'h0;
        resp_ready = 1'b1;
        repeat (4) cyc();

        check_eq("sb_empty", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder_arbiter
`default_nettype wire
